// File: rtl/sat_pkg.sv
// Shared SAT datapath types: literal layout, clause status and sweep verdict encodings.
package sat_pkg;
  localparam int SAT_VAR_ID_BITS = 8;
  localparam int LIT_W           = SAT_VAR_ID_BITS + 1;
  localparam int NULL_VAR        = 0;

  typedef struct packed {
    logic [SAT_VAR_ID_BITS-1:0] var_id;
    logic                       neg;
  } lit_t;

  typedef enum logic [1:0] {
    CL_SAT       = 2'd0,
    CL_UNDECIDED = 2'd1,
    CL_UNIT      = 2'd2,
    CL_CONFLICT  = 2'd3
  } clause_status_e;

  typedef enum logic [1:0] {
    RES_ALL_SAT   = 2'd0,
    RES_UNDECIDED = 2'd1,
    RES_UNIT      = 2'd2,
    RES_CONFLICT  = 2'd3
  } scan_result_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;
endpackage

// File: rtl/clause_eval.sv
// Combinational single-clause evaluator: classifies one clause against the current
// assignment and reports the position of its lowest free literal.
module clause_eval import sat_pkg::*; #(
  parameter  int VAR_ID_BITS         = 8,
  parameter  int NUM_VARS_PER_CLAUSE = 3,
  localparam int NUM_VARS            = 2**VAR_ID_BITS,
  localparam int LW                  = VAR_ID_BITS + 1,
  localparam int POS_BITS            = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1
) (
  input  logic [LW*NUM_VARS_PER_CLAUSE-1:0] clause,
  input  logic [NUM_VARS-1:0]               assign_valid,
  input  logic [NUM_VARS-1:0]               assign_value,
  output clause_status_e                    status,
  output logic [POS_BITS-1:0]               free_pos
);
  logic [NUM_VARS_PER_CLAUSE-1:0] lit_live;
  logic [NUM_VARS_PER_CLAUSE-1:0] lit_true;
  logic [NUM_VARS_PER_CLAUSE-1:0] lit_free;

  generate
    for (genvar gi = 0; gi < NUM_VARS_PER_CLAUSE; gi++) begin : g_lit
      logic [VAR_ID_BITS-1:0] var_id;
      logic                   neg;
      assign var_id       = clause[gi*LW+1 +: VAR_ID_BITS];
      assign neg          = clause[gi*LW];
      assign lit_live[gi] = (var_id != VAR_ID_BITS'(NULL_VAR));
      assign lit_true[gi] = lit_live[gi] && assign_valid[var_id] && (assign_value[var_id] ^ neg);
      assign lit_free[gi] = lit_live[gi] && !assign_valid[var_id];
    end
  endgenerate

  always_comb begin
    free_pos = '0;
    // Walk downward so the lowest free literal wins.
    for (int k = NUM_VARS_PER_CLAUSE - 1; k >= 0; k--) begin
      if (lit_free[k]) free_pos = POS_BITS'(k);
    end
    if (|lit_true)                       status = CL_SAT;
    else if (lit_free == '0)             status = (|lit_live) ? CL_CONFLICT : CL_SAT;
    else if ($countones(lit_free) == 1)  status = CL_UNIT;
    else                                 status = CL_UNDECIDED;
  end
endmodule

// File: rtl/clause_scan_engine.sv
// Sweeps the clause memory row by row and reduces every clause to one sweep verdict.
// Build macro CLAUSE_SCAN_EARLY_ABORT_EN ends the sweep at the first flagged conflict.
module clause_scan_engine import sat_pkg::*; #(
  parameter  int NUM_CLAUSES           = 64,
  parameter  int VAR_ID_BITS           = 8,
  parameter  int NUM_CLAUSES_PER_CYCLE = 16,
  parameter  int NUM_VARS_PER_CLAUSE   = 3,
  parameter  int PTR_BITS              = $clog2(NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE),
  localparam int NUM_VARS              = 2**VAR_ID_BITS,
  localparam int LW                    = VAR_ID_BITS + 1,
  localparam int CW                    = LW * NUM_VARS_PER_CLAUSE,
  localparam int SLICE_W               = CW * NUM_CLAUSES_PER_CYCLE,
  localparam int IDX_BITS              = $clog2(NUM_CLAUSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_VARS-1:0]    assign_valid,
  input  logic [NUM_VARS-1:0]    assign_value,
  output logic [PTR_BITS-1:0]    row_ptr,
  input  logic [SLICE_W-1:0]     mem_slice,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             result,
  output logic [IDX_BITS-1:0]    clause_idx,
  output logic [VAR_ID_BITS-1:0] unit_var,
  output logic                   unit_neg
);
  localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
  localparam int NC       = NUM_CLAUSES_PER_CYCLE;
  localparam int LOC_BITS = (NC > 1) ? $clog2(NC) : 1;
  localparam int POS_BITS = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1;

  scan_state_e          state_reg;
  logic [PTR_BITS-1:0]  row_ptr_reg;
  logic                 drain_cnt_reg;
  logic                 busy_reg, done_reg, unit_neg_reg;
  scan_result_e         result_reg;
  logic [IDX_BITS-1:0]  clause_idx_reg;
  logic [VAR_ID_BITS-1:0] unit_var_reg;

  logic                 s1_valid_reg, s2_valid_reg;
  logic [SLICE_W-1:0]   s1_slice_reg;
  logic [PTR_BITS-1:0]  s1_row_reg, s2_row_reg;
  clause_status_e       s2_status_reg [NC];
  logic [LW-1:0]        s2_lit_reg    [NC];
  clause_status_e       eval_status   [NC];
  logic [LW-1:0]        eval_lit      [NC];

  logic                 acc_conf_reg, acc_unit_reg, acc_undec_reg;
  logic [IDX_BITS-1:0]  acc_conf_idx_reg, acc_unit_idx_reg;
  logic [LW-1:0]        acc_unit_lit_reg;

  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_clause
      logic [POS_BITS-1:0] free_pos;
      clause_eval #(
        .VAR_ID_BITS         (VAR_ID_BITS),
        .NUM_VARS_PER_CLAUSE (NUM_VARS_PER_CLAUSE)
      ) u_eval (
        .clause       (s1_slice_reg[gi*CW +: CW]),
        .assign_valid (assign_valid),
        .assign_value (assign_value),
        .status       (eval_status[gi]),
        .free_pos     (free_pos)
      );
      assign eval_lit[gi] = s1_slice_reg[gi*CW + int'(free_pos)*LW +: LW];
    end
  endgenerate

  // Lowest-index priority encoder over the registered stage-2 row.
  logic                row_conf, row_unit, row_undec;
  logic [LOC_BITS-1:0] row_conf_loc, row_unit_loc;
  logic [LW-1:0]       row_unit_lit;
  always_comb begin
    row_conf = 1'b0; row_unit = 1'b0; row_undec = 1'b0;
    row_conf_loc = '0; row_unit_loc = '0; row_unit_lit = '0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (s2_status_reg[i] == CL_CONFLICT) begin
        row_conf = 1'b1; row_conf_loc = LOC_BITS'(i);
      end
      if (s2_status_reg[i] == CL_UNIT) begin
        row_unit = 1'b1; row_unit_loc = LOC_BITS'(i); row_unit_lit = s2_lit_reg[i];
      end
      if (s2_status_reg[i] == CL_UNDECIDED) row_undec = 1'b1;
    end
  end

  // Rows arrive in ascending order, so the first hit recorded is the lowest index.
  logic                m_conf, m_unit, m_undec;
  logic [IDX_BITS-1:0] m_conf_idx, m_unit_idx;
  logic [LW-1:0]       m_unit_lit;
  always_comb begin
    m_conf = acc_conf_reg; m_conf_idx = acc_conf_idx_reg;
    m_unit = acc_unit_reg; m_unit_idx = acc_unit_idx_reg; m_unit_lit = acc_unit_lit_reg;
    m_undec = acc_undec_reg;
    if (s2_valid_reg) begin
      if (!acc_conf_reg && row_conf) begin
        m_conf = 1'b1;
        m_conf_idx = IDX_BITS'(int'(s2_row_reg) * NC + int'(row_conf_loc));
      end
      if (!acc_unit_reg && row_unit) begin
        m_unit = 1'b1;
        m_unit_idx = IDX_BITS'(int'(s2_row_reg) * NC + int'(row_unit_loc));
        m_unit_lit = row_unit_lit;
      end
      m_undec = acc_undec_reg | row_undec;
    end
  end

  scan_result_e        fin_result;
  logic [IDX_BITS-1:0] fin_idx;
  logic [LW-1:0]       fin_lit;
  always_comb begin
    fin_idx = '0; fin_lit = '0;
    if (m_conf) begin
      fin_result = RES_CONFLICT; fin_idx = m_conf_idx;
    end else if (m_unit) begin
      fin_result = RES_UNIT; fin_idx = m_unit_idx; fin_lit = m_unit_lit;
    end else if (m_undec) begin
      fin_result = RES_UNDECIDED;
    end else begin
      fin_result = RES_ALL_SAT;
    end
  end

  logic abort;
`ifdef CLAUSE_SCAN_EARLY_ABORT_EN
  assign abort = s2_valid_reg && row_conf && (state_reg == ST_SCAN || state_reg == ST_DRAIN);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE; row_ptr_reg <= '0; drain_cnt_reg <= 1'b0;
      busy_reg <= 1'b0; done_reg <= 1'b0; result_reg <= RES_ALL_SAT;
      clause_idx_reg <= '0; unit_var_reg <= '0; unit_neg_reg <= 1'b0;
      s1_valid_reg <= 1'b0; s2_valid_reg <= 1'b0; s1_slice_reg <= '0;
      s1_row_reg <= '0; s2_row_reg <= '0;
      for (int i = 0; i < NC; i++) begin
        s2_status_reg[i] <= CL_SAT; s2_lit_reg[i] <= '0;
      end
      acc_conf_reg <= 1'b0; acc_unit_reg <= 1'b0; acc_undec_reg <= 1'b0;
      acc_conf_idx_reg <= '0; acc_unit_idx_reg <= '0; acc_unit_lit_reg <= '0;
    end else begin
      done_reg     <= 1'b0;
      s1_valid_reg <= (state_reg == ST_SCAN) && !abort;
      s1_slice_reg <= mem_slice;
      s1_row_reg   <= row_ptr_reg;
      s2_valid_reg <= s1_valid_reg && !abort;
      s2_row_reg   <= s1_row_reg;
      for (int i = 0; i < NC; i++) begin
        s2_status_reg[i] <= eval_status[i]; s2_lit_reg[i] <= eval_lit[i];
      end
      acc_conf_reg <= m_conf; acc_conf_idx_reg <= m_conf_idx;
      acc_unit_reg <= m_unit; acc_unit_idx_reg <= m_unit_idx; acc_unit_lit_reg <= m_unit_lit;
      acc_undec_reg <= m_undec;
      case (state_reg)
        ST_IDLE: if (start) begin
          state_reg <= ST_SCAN; busy_reg <= 1'b1; row_ptr_reg <= '0;
          acc_conf_reg <= 1'b0; acc_unit_reg <= 1'b0; acc_undec_reg <= 1'b0;
        end
        ST_SCAN: if (row_ptr_reg == PTR_BITS'(NUM_ROWS - 1)) begin
          state_reg <= ST_DRAIN; row_ptr_reg <= '0; drain_cnt_reg <= 1'b0;
        end else begin
          row_ptr_reg <= row_ptr_reg + PTR_BITS'(1);
        end
        ST_DRAIN: drain_cnt_reg <= 1'b1;
        ST_DONE: begin
          state_reg <= ST_IDLE; busy_reg <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (abort || (state_reg == ST_DRAIN && drain_cnt_reg)) begin
        state_reg <= ST_DONE; row_ptr_reg <= '0; done_reg <= 1'b1;
        result_reg <= fin_result; clause_idx_reg <= fin_idx;
        unit_var_reg <= fin_lit[LW-1:1]; unit_neg_reg <= fin_lit[0];
      end
    end
  end

  assign row_ptr    = row_ptr_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign result     = result_reg;
  assign clause_idx = clause_idx_reg;
  assign unit_var   = unit_var_reg;
  assign unit_neg   = unit_neg_reg;
endmodule

// File: tb/tb_clause_scan_engine.sv
// Self-checking bench for clause_scan_engine: directed scenarios plus randomized clause
// sets checked against a clause-by-clause reference model.
`timescale 1ns/1ps
module tb_clause_scan_engine;
  localparam int NUM_CLAUSES = 64;
  localparam int NCPC        = 16;
  localparam int K           = 3;
  localparam int LW          = 9;
  localparam int CW          = LW * K;
  localparam int SLICE_W     = CW * NCPC;
  localparam int NUM_ROWS    = NUM_CLAUSES / NCPC;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [255:0]       assign_valid, assign_value;
  logic [1:0]         row_ptr;
  logic [SLICE_W-1:0] mem_slice;
  logic               busy, done;
  logic [1:0]         result;
  logic [5:0]         clause_idx;
  logic [7:0]         unit_var;
  logic               unit_neg;

  logic [SLICE_W-1:0] mem [NUM_ROWS];
  assign mem_slice = mem[row_ptr];

  int cl_var [NUM_CLAUSES][K];
  bit cl_neg [NUM_CLAUSES][K];
  int passed = 0;
  int total  = 0;
  int exp_result, exp_idx, exp_uvar, exp_lat;
  bit exp_uneg;
  int rp_hist [64];
  bit busy_hist [64];

  clause_scan_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .assign_valid(assign_valid), .assign_value(assign_value),
    .row_ptr(row_ptr), .mem_slice(mem_slice),
    .busy(busy), .done(done), .result(result), .clause_idx(clause_idx),
    .unit_var(unit_var), .unit_neg(unit_neg)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_setup();
    for (int c = 0; c < NUM_CLAUSES; c++)
      for (int k = 0; k < K; k++) begin
        cl_var[c][k] = 0; cl_neg[c][k] = 1'b0;
      end
    assign_valid = '0; assign_value = '0;
  endtask

  task automatic load_mem();
    logic [LW-1:0] lit;
    for (int r = 0; r < NUM_ROWS; r++) mem[r] = '0;
    for (int c = 0; c < NUM_CLAUSES; c++)
      for (int k = 0; k < K; k++) begin
        lit = {8'(cl_var[c][k]), cl_neg[c][k]};
        mem[c / NCPC][(c % NCPC) * CW + k * LW +: LW] = lit;
      end
  endtask

  // Reference model: classify every clause, then apply the sweep priority rules.
  task automatic compute_model();
    bit found_conf, found_unit, any_undec;
    int conf_idx, unit_idx, uvar;
    bit uneg;
    found_conf = 0; found_unit = 0; any_undec = 0;
    conf_idx = 0; unit_idx = 0; uvar = 0; uneg = 0;
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      int ntrue, nfree, nlive, fv;
      bit fn;
      ntrue = 0; nfree = 0; nlive = 0; fv = 0; fn = 0;
      for (int k = 0; k < K; k++) begin
        int v;
        v = cl_var[c][k];
        if (v != 0) begin
          nlive++;
          if (!assign_valid[v]) begin
            if (nfree == 0) begin fv = v; fn = cl_neg[c][k]; end
            nfree++;
          end else if (assign_value[v] ^ cl_neg[c][k]) ntrue++;
        end
      end
      if (ntrue > 0 || nlive == 0) begin
      end else if (nfree == 0) begin
        if (!found_conf) begin found_conf = 1; conf_idx = c; end
      end else if (nfree == 1) begin
        if (!found_unit) begin found_unit = 1; unit_idx = c; uvar = fv; uneg = fn; end
      end else any_undec = 1;
    end
    exp_idx = 0; exp_uvar = 0; exp_uneg = 0; exp_lat = 7;
    if (found_conf) begin
      exp_result = 3; exp_idx = conf_idx;
`ifdef CLAUSE_SCAN_EARLY_ABORT_EN
      exp_lat = conf_idx / NCPC + 4;
`endif
    end else if (found_unit) begin
      exp_result = 2; exp_idx = unit_idx; exp_uvar = uvar; exp_uneg = uneg;
    end else if (any_undec) exp_result = 1;
    else exp_result = 0;
  endtask

  // Caller is in a cycle with the DUT idle; returns in the done cycle (lat = cycles after start edge).
  task automatic run_sweep(output int lat);
    lat = 0;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rp_hist[c] = int'(row_ptr); busy_hist[c] = busy;
      if (done) begin lat = c; break; end
      next_cycle();
    end
    $display("sweep: lat=%0d result=%0d clause_idx=%0d unit_var=%0d unit_neg=%0d",
             lat, result, clause_idx, unit_var, unit_neg);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear_setup(); load_mem();
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();
    total++; if (row_ptr !== 2'd0) $display("FAIL reset_row_ptr: got %0d want 0", row_ptr); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
    total++; if (result !== 2'd0) $display("FAIL reset_result: got %0d want 0", result); else passed++;
    total++; if (clause_idx !== 6'd0) $display("FAIL reset_clause_idx: got %0d want 0", clause_idx); else passed++;
    total++; if (unit_var !== 8'd0) $display("FAIL reset_unit_var: got %0d want 0", unit_var); else passed++;
    total++; if (unit_neg !== 1'b0) $display("FAIL reset_unit_neg: got %0b want 0", unit_neg); else passed++;
  endtask

  task automatic test_all_sat();
    int lat;
    clear_setup(); load_mem();
    run_sweep(lat);
    total++; if (lat !== 7) $display("FAIL allsat_latency: got %0d want 7", lat); else passed++;
    total++; if (result !== 2'd0) $display("FAIL allsat_result: got %0d want 0", result); else passed++;
    total++; if (clause_idx !== 6'd0) $display("FAIL allsat_idx: got %0d want 0", clause_idx); else passed++;
    for (int c = 1; c <= 7; c++) begin
      int want_rp;
      want_rp = (c <= NUM_ROWS) ? c - 1 : 0;
      total++; if (rp_hist[c] !== want_rp) $display("FAIL allsat_row_ptr_c%0d: got %0d want %0d", c, rp_hist[c], want_rp); else passed++;
      total++; if (busy_hist[c] !== 1'b1) $display("FAIL allsat_busy_c%0d: got %0b want 1", c, busy_hist[c]); else passed++;
    end
    next_cycle();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL allsat_idle_after: busy=%0b done=%0b want 0/0", busy, done); else passed++;
  endtask

  task automatic test_conflict();
    int lat;
    clear_setup();
    cl_var[5][0] = 3; cl_var[5][1] = 4; cl_neg[5][1] = 1'b1;
    assign_valid[3] = 1'b1; assign_value[3] = 1'b0;
    assign_valid[4] = 1'b1; assign_value[4] = 1'b1;
    load_mem(); compute_model();
    run_sweep(lat);
    total++; if (result !== 2'd3) $display("FAIL conflict_result: got %0d want 3", result); else passed++;
    total++; if (clause_idx !== 6'd5) $display("FAIL conflict_idx: got %0d want 5", clause_idx); else passed++;
    total++; if (unit_var !== 8'd0 || unit_neg !== 1'b0) $display("FAIL conflict_unit_lit: got %0d/%0b want 0/0", unit_var, unit_neg); else passed++;
    total++; if (lat !== exp_lat) $display("FAIL conflict_latency: got %0d want %0d", lat, exp_lat); else passed++;
    next_cycle();
  endtask

  task automatic test_unit();
    int lat;
    clear_setup();
    cl_var[20][0] = 1; cl_var[20][1] = 2; cl_var[20][2] = 7;
    assign_valid[1] = 1'b1; assign_valid[2] = 1'b1;
    load_mem();
    run_sweep(lat);
    total++; if (result !== 2'd2) $display("FAIL unit_result: got %0d want 2", result); else passed++;
    total++; if (clause_idx !== 6'd20) $display("FAIL unit_idx: got %0d want 20", clause_idx); else passed++;
    total++; if (unit_var !== 8'd7) $display("FAIL unit_var: got %0d want 7", unit_var); else passed++;
    total++; if (unit_neg !== 1'b0) $display("FAIL unit_neg: got %0b want 0", unit_neg); else passed++;
    total++; if (lat !== 7) $display("FAIL unit_latency: got %0d want 7", lat); else passed++;
    next_cycle();
  endtask

  task automatic test_priority();
    int lat, want_lat;
    clear_setup();
    cl_var[40][0] = 3; cl_var[40][1] = 4; cl_neg[40][1] = 1'b1;
    cl_var[50][2] = 4; cl_neg[50][2] = 1'b1;
    cl_var[3][0] = 1; cl_var[3][1] = 9;
    assign_valid[1] = 1'b1; assign_valid[3] = 1'b1;
    assign_valid[4] = 1'b1; assign_value[4] = 1'b1;
    load_mem();
`ifdef CLAUSE_SCAN_EARLY_ABORT_EN
    want_lat = 6;
`else
    want_lat = 7;
`endif
    run_sweep(lat);
    total++; if (result !== 2'd3) $display("FAIL prio_result: got %0d want 3", result); else passed++;
    total++; if (clause_idx !== 6'd40) $display("FAIL prio_idx: got %0d want 40", clause_idx); else passed++;
    total++; if (lat !== want_lat) $display("FAIL prio_latency: got %0d want %0d", lat, want_lat); else passed++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int lat, done_seen, busy_seen;
    start = 1'b1; next_cycle(); start = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b1; next_cycle(); rst = 1'b0;
    done_seen = 0; busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) done_seen++;
      if (busy) busy_seen++;
      next_cycle();
    end
    total++; if (done_seen !== 0) $display("FAIL midrst_done: got %0d pulses want 0", done_seen); else passed++;
    total++; if (busy_seen !== 0) $display("FAIL midrst_busy: got %0d busy cycles want 0", busy_seen); else passed++;
    total++; if (result !== 2'd0 || clause_idx !== 6'd0) $display("FAIL midrst_outputs: result=%0d idx=%0d want 0/0", result, clause_idx); else passed++;
    total++; if (row_ptr !== 2'd0) $display("FAIL midrst_row_ptr: got %0d want 0", row_ptr); else passed++;
    $display("mid-sweep reset: done pulses=%0d busy cycles=%0d", done_seen, busy_seen);
    clear_setup();
    cl_var[33][1] = 12; cl_neg[33][1] = 1'b1;
    load_mem(); compute_model();
    run_sweep(lat);
    total++; if (result !== 2'(exp_result)) $display("FAIL midrst_fresh_result: got %0d want %0d", result, exp_result); else passed++;
    total++; if (clause_idx !== 6'(exp_idx) || unit_var !== 8'(exp_uvar) || unit_neg !== exp_uneg)
      $display("FAIL midrst_fresh_unit: got %0d/%0d/%0b want %0d/%0d/%0b", clause_idx, unit_var, unit_neg, exp_idx, exp_uvar, exp_uneg); else passed++;
    total++; if (lat !== 7) $display("FAIL midrst_fresh_latency: got %0d want 7", lat); else passed++;
    next_cycle();
  endtask

  task automatic test_start_held();
    int ndone, bad_rp;
    int done_at [4];
    clear_setup(); load_mem();
    ndone = 0; bad_rp = 0;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) start = 1'b0;
      next_cycle();
      if (done) begin
        if (ndone < 4) done_at[ndone] = c + 1;
        ndone++;
      end
      if (!busy && row_ptr !== 2'd0) bad_rp++;
    end
    $display("held start: done pulses=%0d", ndone);
    total++; if (ndone !== 2) $display("FAIL held_sweeps: got %0d want 2", ndone); else passed++;
    if (ndone >= 2) begin
      total++; if (done_at[0] !== 7) $display("FAIL held_first_done: got %0d want 7", done_at[0]); else passed++;
      total++; if (done_at[1] !== 15) $display("FAIL held_second_done: got %0d want 15", done_at[1]); else passed++;
    end
    total++; if (bad_rp !== 0) $display("FAIL held_idle_row_ptr: got %0d nonzero cycles want 0", bad_rp); else passed++;
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 10; t++) begin
      clear_setup();
      for (int c = 0; c < NUM_CLAUSES; c++)
        if ($urandom_range(3) == 0)
          for (int k = 0; k < K; k++) begin
            cl_var[c][k] = int'($urandom_range(7));
            cl_neg[c][k] = 1'($urandom_range(1));
          end
      for (int v = 0; v < 256; v++) begin
        assign_valid[v] = ($urandom_range(3) != 0);
        assign_value[v] = 1'($urandom_range(1));
      end
      load_mem(); compute_model();
      run_sweep(lat);
      total++; if (result !== 2'(exp_result)) $display("FAIL rand%0d_result: got %0d want %0d", t, result, exp_result); else passed++;
      total++; if (clause_idx !== 6'(exp_idx)) $display("FAIL rand%0d_idx: got %0d want %0d", t, clause_idx, exp_idx); else passed++;
      total++; if (unit_var !== 8'(exp_uvar)) $display("FAIL rand%0d_unit_var: got %0d want %0d", t, unit_var, exp_uvar); else passed++;
      total++; if (unit_neg !== exp_uneg) $display("FAIL rand%0d_unit_neg: got %0b want %0b", t, unit_neg, exp_uneg); else passed++;
      total++; if (lat !== exp_lat) $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, exp_lat); else passed++;
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    assign_valid = '0; assign_value = '0;
    test_reset();
    test_all_sat();
    test_conflict();
    test_unit();
    test_priority();
    test_reset_mid();
    test_start_held();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
